// File: rtl/rsa_modexp_unit.sv
// Modular exponentiation engine: cypher = plain^exp mod modulus, right-to-left binary
// exponentiation with bit-serial interleaved modular multiplies, fixed latency.
module rsa_modexp_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             en_rsa,
  input  logic             rst_rsa,
  input  logic [WIDTH-1:0] plain_text,
  input  logic [WIDTH-1:0] exp_e,
  input  logic [WIDTH-1:0] mod_m,
  output logic [WIDTH-1:0] cypher,
  output logic             eoc_rsa_unit
);

  localparam int PW = WIDTH + 2;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] m_reg, m_next;
  logic [WIDTH-1:0] e_reg, e_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [PW-1:0]    pr_reg, pr_next;
  logic [PW-1:0]    pb_reg, pb_next;
  logic [IW-1:0]    k_reg, k_next;
  logic [IW-1:0]    i_reg, i_next;
  logic [WIDTH-1:0] cypher_reg, cypher_next;
  logic             eoc_reg, eoc_next;

  logic [PW-1:0]    m_ext, pr_base, pb_base, pr_step, pb_step;
  logic             bit_b;

  // One shift-add step followed by two conditional subtractions keeps the accumulator below M.
  function automatic logic [PW-1:0] mod_step(input logic [PW-1:0]    acc,
                                             input logic [WIDTH-1:0] addend,
                                             input logic             add_en,
                                             input logic [PW-1:0]    m);
    logic [PW-1:0] t;
    t = {acc[PW-2:0], 1'b0} + (add_en ? {2'b00, addend} : {PW{1'b0}});
    if (t >= m) t = t - m;
    if (t >= m) t = t - m;
    return t;
  endfunction

  always_comb begin
    m_ext   = {2'b00, m_reg};
    pr_base = (i_reg == IW'(WIDTH-1)) ? '0 : pr_reg;
    pb_base = (i_reg == IW'(WIDTH-1)) ? '0 : pb_reg;
    bit_b   = b_reg[i_reg];
    pr_step = mod_step(pr_base, r_reg, bit_b, m_ext);
    pb_step = mod_step(pb_base, b_reg, bit_b, m_ext);
  end

  always_comb begin
    state_next  = state_reg;
    m_next      = m_reg;
    e_next      = e_reg;
    r_next      = r_reg;
    b_next      = b_reg;
    pr_next     = pr_reg;
    pb_next     = pb_reg;
    k_next      = k_reg;
    i_next      = i_reg;
    cypher_next = cypher_reg;
    eoc_next    = eoc_reg;
    case (state_reg)
      IDLE: begin
        eoc_next   = 1'b0;
        state_next = LOAD;
      end
      LOAD: begin
        m_next     = mod_m;
        e_next     = exp_e;
        b_next     = plain_text;
        r_next     = (mod_m < WIDTH'(2)) ? '0 : WIDTH'(1);
        pr_next    = '0;
        pb_next    = '0;
        k_next     = '0;
        i_next     = IW'(WIDTH-1);
        state_next = MULT;
      end
      MULT: begin
        pr_next = pr_step;
        pb_next = pb_step;
        if (i_reg == '0) begin
          // R*B is always computed; it is only committed when the exponent bit is set.
          if (e_reg[k_reg]) r_next = pr_step[WIDTH-1:0];
          b_next = pb_step[WIDTH-1:0];
          i_next = IW'(WIDTH-1);
          k_next = k_reg + 1'b1;
          if (k_reg == IW'(WIDTH-1)) begin
            cypher_next = (m_reg < WIDTH'(2)) ? '0 :
                          (e_reg[k_reg] ? pr_step[WIDTH-1:0] : r_reg);
            eoc_next    = 1'b1;
            state_next  = DONE;
          end
        end else begin
          i_next = i_reg - 1'b1;
        end
      end
      DONE: begin
        eoc_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg  <= IDLE;
      m_reg      <= '0;
      e_reg      <= '0;
      r_reg      <= '0;
      b_reg      <= '0;
      pr_reg     <= '0;
      pb_reg     <= '0;
      k_reg      <= '0;
      i_reg      <= '0;
      cypher_reg <= '0;
      eoc_reg    <= 1'b0;
    end else if (ena) begin
      if (!rst_rsa) begin
        // Functional abort: back to IDLE, previous result stays visible.
        state_reg <= IDLE;
        eoc_reg   <= 1'b0;
      end else if (en_rsa) begin
        state_reg  <= state_next;
        m_reg      <= m_next;
        e_reg      <= e_next;
        r_reg      <= r_next;
        b_reg      <= b_next;
        pr_reg     <= pr_next;
        pb_reg     <= pb_next;
        k_reg      <= k_next;
        i_reg      <= i_next;
        cypher_reg <= cypher_next;
        eoc_reg    <= eoc_next;
      end
    end
  end

  assign cypher       = cypher_reg;
  assign eoc_rsa_unit = eoc_reg;

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Self-checking bench for rsa_modexp_unit: directed vectors plus random operands against
// a plain-arithmetic modexp model, with latency, hold, abort, pause and async reset checks.
module tb_rsa_modexp_unit;

  logic       clk;
  logic       rstb;
  logic       ena;
  logic       en_rsa;
  logic       rst_rsa;
  logic [7:0] plain_text;
  logic [7:0] exp_e;
  logic [7:0] mod_m;
  logic [7:0] cypher;
  logic       eoc_rsa_unit;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_cypher;

  rsa_modexp_unit #(.WIDTH(8)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .ena          (ena),
    .en_rsa       (en_rsa),
    .rst_rsa      (rst_rsa),
    .plain_text   (plain_text),
    .exp_e        (exp_e),
    .mod_m        (mod_m),
    .cypher       (cypher),
    .eoc_rsa_unit (eoc_rsa_unit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ref_modexp(input int p, input int e, input int m);
    int r;
    int b;
    if (m < 2) return 8'd0;
    r = 1;
    b = p % m;
    for (int k = 0; k < 8; k++) begin
      if (((e >> k) & 1) == 1) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[7:0];
  endfunction

  // mode: 0 normal, 1 en_rsa pause, 2 ena pause, 3 abort at edge 30, 4 rstb pulse at edge 30
  task automatic do_run(input string tag, input logic [7:0] p, input logic [7:0] e,
                        input logic [7:0] m, input int mode);
    int   cnt;
    int   exp_lat;
    bit   stop;
    logic [7:0] exp_c;
    exp_c = ref_modexp(p, e, m);
    plain_text = p; exp_e = e; mod_m = m;
    ena = 1'b1; en_rsa = 1'b1; rst_rsa = 1'b0;
    @(posedge clk); #1;
    rst_rsa = 1'b1;
    cnt = 0;
    stop = 1'b0;
    while (!eoc_rsa_unit && cnt < 200 && !stop) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 10) begin
        plain_text = 8'($urandom); exp_e = 8'($urandom); mod_m = 8'($urandom);
      end
      if (mode == 1 && cnt == 20) en_rsa = 1'b0;
      if (mode == 1 && cnt == 30) en_rsa = 1'b1;
      if (mode == 2 && cnt == 20) ena = 1'b0;
      if (mode == 2 && cnt == 30) ena = 1'b1;
      if (mode == 3 && cnt == 30) rst_rsa = 1'b0;
      if (mode == 4 && cnt == 30) begin
        rstb = 1'b0;
        #2;
        check_val({tag, ":rstb_cypher"}, 32'(cypher), 32'd0);
        check_val({tag, ":rstb_eoc"}, 32'(eoc_rsa_unit), 32'd0);
        rstb = 1'b1;
        model_cypher = 8'd0;
        stop = 1'b1;
      end
    end
    if (mode == 3) begin
      check_val({tag, ":abort_eoc"}, 32'(eoc_rsa_unit), 32'd0);
      check_val({tag, ":abort_cypher"}, 32'(cypher), 32'(model_cypher));
      $display("run %s p=%0d e=%0d m=%0d aborted cypher=%0d", tag, p, e, m, cypher);
    end else if (mode != 4) begin
      exp_lat = (mode == 1 || mode == 2) ? 76 : 66;
      check_val({tag, ":lat"}, 32'(cnt), 32'(exp_lat));
      check_val({tag, ":cypher"}, 32'(cypher), 32'(exp_c));
      model_cypher = exp_c;
      $display("run %s p=%0d e=%0d m=%0d cypher=%0d exp=%0d lat=%0d", tag, p, e, m,
               cypher, exp_c, cnt);
      repeat (5) @(posedge clk);
      #1;
      check_val({tag, ":eoc_hold"}, 32'(eoc_rsa_unit), 32'd1);
      rst_rsa = 1'b0;
      @(posedge clk); #1;
      check_val({tag, ":eoc_drop"}, 32'(eoc_rsa_unit), 32'd0);
      check_val({tag, ":cypher_kept"}, 32'(cypher), 32'(exp_c));
    end else begin
      $display("run %s p=%0d e=%0d m=%0d interrupted by rstb", tag, p, e, m);
    end
  endtask

  initial begin
    int m;
    int p;
    int e;
    rstb = 1'b0; ena = 1'b0; en_rsa = 1'b0; rst_rsa = 1'b0;
    plain_text = '0; exp_e = '0; mod_m = '0;
    model_cypher = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_cypher", 32'(cypher), 32'd0);
    check_val("reset_eoc", 32'(eoc_rsa_unit), 32'd0);
    rstb = 1'b1;

    do_run("tv_5_3_33",   8'd5, 8'd3,   8'd33,  0);
    do_run("abort",       8'd7, 8'd13,  8'd33,  3);
    do_run("tv_7_13_33",  8'd7, 8'd13,  8'd33,  0);
    do_run("tv_2_255_251",8'd2, 8'd255, 8'd251, 0);
    do_run("exp0",        8'd10,8'd0,   8'd33,  0);
    do_run("mod1",        8'd5, 8'd3,   8'd1,   0);
    do_run("mod0",        8'd5, 8'd3,   8'd0,   0);
    do_run("pause_en",    8'd9, 8'd77,  8'd101, 1);
    do_run("pause_ena",   8'd3, 8'd200, 8'd97,  2);
    do_run("rstb_pulse",  8'd4, 8'd5,   8'd55,  4);
    do_run("after_rstb",  8'd4, 8'd5,   8'd55,  0);

    for (int n = 0; n < 8; n++) begin
      m = $urandom_range(255, 2);
      p = $urandom_range(m - 1, 0);
      e = $urandom_range(255, 0);
      do_run($sformatf("rand%0d", n), 8'(p), 8'(e), 8'(m), (n % 3 == 2) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_unit.md
Name: rsa_modexp_unit

Overview:
- Responder side of the RSA enable/reset/end-of-conversion handshake: the modular exponentiation engine driven by the en/rst control FSM.
- Computes cypher = plain^exp mod modulus using right-to-left binary exponentiation with bit-serial interleaved (shift-add-subtract) modular multiplication.
- Constant time: latency is independent of operand values.
- Sits between the control FSM (en_rsa, rst_rsa in; eoc_rsa_unit out) and the SPI register file (operands in, cypher out).

Parameters:
WIDTH, 8, operand/result width in bits (plain, exp, modulus, cypher)

Ports:
clk  input  1  system clock, rising edge
rstb  input  1  asynchronous active-low reset
ena  input  1  global clock-qualifier; no register updates when low
en_rsa  input  1  unit enable from control FSM; low = freeze (hold all state)
rst_rsa  input  1  synchronous active-low functional reset from control FSM; low = abort/idle
plain_text  input  WIDTH  message operand
exp_e  input  WIDTH  exponent operand
mod_m  input  WIDTH  modulus operand
cypher  output  WIDTH  result, registered
eoc_rsa_unit  output  1  end of conversion, registered, level

Behaviour:
- rstb low (async): state=IDLE, all internal registers 0, cypher=0, eoc_rsa_unit=0.
- Qualifying edge = rising clk with ena=1. Nothing updates on a non-qualifying edge.
- Priority on each qualifying edge:
  - rst_rsa=0: state<=IDLE, eoc<=0, cypher held. This applies regardless of en_rsa and aborts any computation.
  - Else en_rsa=0: hold everything (pause).
  - Else advance the FSM.
- IDLE: eoc=0. On the next advancing edge go to LOAD.
- LOAD (1 edge):
  - Latch M=mod_m, E=exp_e.
  - B<=plain_text; R<=1, or R<=0 if mod_m<2.
  - Clear bit index k=0 and iteration index i=WIDTH-1.
  - Go to MULT.
- MULT (WIDTH*WIDTH edges): two parallel multipliers, Pr (R*B) and Pb (B*B), each WIDTH+2 bits wide.
  - Pr and Pb are cleared at the start of every bit step.
  - Iteration i, with b=B[i]:
    - Pr' = 2Pr + (b ? R : 0); Pb' = 2Pb + (b ? B : 0).
    - Each result then takes up to two conditional subtractions: if ≥M subtract M, then if still ≥M subtract M again.
  - After iteration i=0 (end of bit step k):
    - If E[k]=1, R<=Pr.
    - B<=Pb.
    - k<=k+1, i<=WIDTH-1.
    - The R*B multiply always executes; the result is committed only when the exponent bit is set.
  - After the step with k=WIDTH-1: cypher<=(M<2 ? 0 : new R), eoc<=1, go to DONE.
- DONE: eoc held at 1 and cypher held until rst_rsa=0. This is compatible with the controller dwelling in its EOC state before dropping en/rst.
- Latency: eoc_rsa_unit rises exactly 2+WIDTH*WIDTH advancing edges after the first advancing edge in IDLE. For WIDTH=8 that is 66 edges, with no pauses.
- Operand inputs are sampled only in LOAD. Changes afterwards have no effect.
- Boundaries:
  - exp=0 gives cypher=1 (M≥2).
  - mod_m<2 gives cypher=0 with unchanged latency.
  - plain_text≥mod_m: result value unspecified, but latency and eoc behaviour are unchanged.
- cypher changes only on DONE entry (or rstb). An aborted run leaves the previous cypher intact.
- Undefined FSM encoding: go to IDLE.

Test Plan:
- rstb pulse mid-run → cypher=0 and eoc=0 immediately (async), unit in IDLE; the next run completes normally.
- WIDTH=8: plain=5, exp=3, mod=33; rst_rsa low 1 cycle then en=rst=1 → eoc rises exactly 66 edges after release, cypher=26; eoc stays 1 until rst_rsa low, then drops on the next edge with cypher still 26.
- plain=7, exp=13, mod=33 → cypher=13. plain=2, exp=255, mod=251 → cypher=32. Both runs take identical latency of 66 edges.
- exp=0, mod=33 → cypher=1. mod=1 and mod=0 → cypher=0. Latency is 66 edges in every case.
- Abort: after a result of 26, start a new run, pull rst_rsa low at edge 30 → eoc never rises, cypher remains 26. Pause: drop en_rsa (or ena) for 10 cycles mid-run → eoc rises at 66+10 and the result is correct.
- Change plain/exp/mod during MULT → result matches the operands sampled at LOAD.
